// File: rtl/kf_pkg.sv
// Shared constants, FSM encoding and fixed-point helpers for the Kalman tracker.
// Helpers work on a 64-bit two's-complement carrier, so W must stay <= 31.
package kf_pkg;

    localparam int unsigned KF_W    = 24;
    localparam int unsigned KF_FRAC = 14;
    localparam longint      SM_MAX  = (longint'(1) <<< (KF_W - 1)) - 1;

    typedef enum logic [2:0] {StIdle, StPred, StCorr, StUpd, StOut} kf_state_e;

    typedef logic signed [63:0] kf_wide_t;

    function automatic kf_wide_t sm_max(input int unsigned w);
        return (kf_wide_t'(1) <<< (w - 1)) - kf_wide_t'(1);
    endfunction

    function automatic kf_wide_t sat_w(input kf_wide_t x, input int unsigned w);
        kf_wide_t lim;
        lim = sm_max(w);
        if (x > lim) return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

    // Negative zero folds to 0 because the magnitude is masked before negation.
    function automatic kf_wide_t sm_to_tc(input logic [63:0] sm, input int unsigned w);
        kf_wide_t   mag;
        logic [63:0] neg;
        mag = $signed(sm) & sm_max(w);
        neg = (sm >> (w - 1)) & 64'd1;
        return (neg != 64'd0) ? -mag : mag;
    endfunction

    function automatic logic [63:0] tc_to_sm(input kf_wide_t x, input int unsigned w);
        logic [63:0] sign;
        sign = 64'd1 << (w - 1);
        if (x < 0) return sign | $unsigned(-x);
        return $unsigned(x);
    endfunction

    function automatic kf_wide_t mul_q(input kf_wide_t a, input kf_wide_t b,
                                       input int unsigned w, input int unsigned frac);
        kf_wide_t prod;
        prod = a * b + (kf_wide_t'(1) <<< (frac - 1));
        return sat_w(prod >>> frac, w);
    endfunction

endpackage

// File: rtl/kf_qmul.sv
// Combinational signed W x W Q(FRAC) multiply: round half-up, shift, symmetric saturate.
module kf_qmul
    import kf_pkg::*;
#(
    parameter int unsigned W    = KF_W,
    parameter int unsigned FRAC = KF_FRAC
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_p
);

    assign o_p = W'(mul_q(kf_wide_t'(i_a), kf_wide_t'(i_b), W, FRAC));

endmodule

// File: rtl/kf_track_mc.sv
// Time-multiplexed multi-channel steady-state position/velocity Kalman tracker.
// One shared Q(FRAC) multiplier serves PRED (dt*v), CORR (K1*r) and UPD (K2*r).
module kf_track_mc
    import kf_pkg::*;
#(
    parameter int unsigned W    = KF_W,
    parameter int unsigned FRAC = KF_FRAC,
    parameter int unsigned NCH  = 4,
    parameter int unsigned CHW  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic [W-1:0]   cfg_k1,
    input  logic [W-1:0]   cfg_k2,
    input  logic [W-1:0]   cfg_dt,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [W-1:0]   in_meas,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [W-1:0]   out_pos,
    output logic [W-1:0]   out_vel,
    output logic           err_ch
);

    // State arrays cover every encodable id; slots >= NCH are never written.
    localparam int unsigned  NSLOT = 1 << CHW;
    localparam logic [CHW:0] NCH_L = (CHW + 1)'(NCH);

    typedef logic signed [W-1:0] tc_t;

    kf_state_e        r_state, w_state_d;
    logic [CHW-1:0]   r_ch;
    tc_t              r_z, r_k1, r_k2, r_dt, r_pp, r_r, r_m1;
    logic             r_kill;
    tc_t              r_p [NSLOT];
    tc_t              r_v [NSLOT];
    logic [NSLOT-1:0] r_init;
    logic [CHW-1:0]   r_out_ch;
    logic [W-1:0]     r_out_pos, r_out_vel;
    logic             r_err;

    logic w_bad_ch, w_accept;
    tc_t  w_p_cur, w_v_cur, w_pp, w_r, w_ma, w_mb, w_prod, w_p_new, w_v_new;

    assign w_bad_ch = ({1'b0, in_ch} >= NCH_L);
    assign w_accept = (r_state == StIdle) && in_valid && !w_bad_ch;
    assign w_p_cur  = r_p[r_ch];
    assign w_v_cur  = r_v[r_ch];
    assign w_pp     = tc_t'(sat_w(kf_wide_t'(w_p_cur) + kf_wide_t'(w_prod), W));
    assign w_r      = tc_t'(sat_w(kf_wide_t'(r_z) - kf_wide_t'(r_pp), W));

    always_comb begin
        w_ma = r_k2;
        w_mb = r_r;
        case (r_state)
            StPred: begin
                w_ma = r_dt;
                w_mb = w_v_cur;
            end
            StCorr: begin
                w_ma = r_k1;
                w_mb = w_r;
            end
            default: ;
        endcase
    end

    kf_qmul #(
        .W    (W),
        .FRAC (FRAC)
    ) u_qmul (
        .i_a (w_ma),
        .i_b (w_mb),
        .o_p (w_prod)
    );

    always_comb begin
        w_p_new = tc_t'(sat_w(kf_wide_t'(r_pp) + kf_wide_t'(r_m1), W));
        w_v_new = tc_t'(sat_w(kf_wide_t'(w_v_cur) + kf_wide_t'(w_prod), W));
        if (!r_init[r_ch]) begin
            w_p_new = r_z;
            w_v_new = '0;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_d = StPred;
            StPred:  w_state_d = StCorr;
            StCorr:  w_state_d = StUpd;
            StUpd:   w_state_d = StOut;
            StOut:   if (out_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_ch      <= '0;
            r_z       <= '0;
            r_k1      <= '0;
            r_k2      <= '0;
            r_dt      <= '0;
            r_pp      <= '0;
            r_r       <= '0;
            r_m1      <= '0;
            r_kill    <= 1'b0;
            r_out_ch  <= '0;
            r_out_pos <= '0;
            r_out_vel <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if ((r_state == StIdle) && in_valid && w_bad_ch) r_err <= 1'b1;
            if (w_accept) begin
                r_ch   <= in_ch;
                r_z    <= tc_t'(sm_to_tc(64'(in_meas), W));
                r_k1   <= tc_t'(sm_to_tc(64'(cfg_k1), W));
                r_k2   <= tc_t'(sm_to_tc(64'(cfg_k2), W));
                r_dt   <= tc_t'(sm_to_tc(64'(cfg_dt), W));
                r_kill <= 1'b0;
            end else if (clr && (r_state inside {StPred, StCorr, StUpd})) begin
                // A clear while in flight still yields a result but no writeback.
                r_kill <= 1'b1;
            end
            if (r_state == StPred) r_pp <= w_pp;
            if (r_state == StCorr) begin
                r_r  <= w_r;
                r_m1 <= w_prod;
            end
            if (r_state == StUpd) begin
                r_out_ch  <= r_ch;
                r_out_pos <= W'(tc_to_sm(kf_wide_t'(w_p_new), W));
                r_out_vel <= W'(tc_to_sm(kf_wide_t'(w_v_new), W));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                r_p[i] <= '0;
                r_v[i] <= '0;
            end
            r_init <= '0;
        end else if (clr) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                r_p[i] <= '0;
                r_v[i] <= '0;
            end
            r_init <= '0;
        end else if ((r_state == StUpd) && !r_kill) begin
            r_p[r_ch]    <= w_p_new;
            r_v[r_ch]    <= w_v_new;
            r_init[r_ch] <= 1'b1;
        end
    end

    assign in_ready  = rst_n && (r_state == StIdle);
    assign out_valid = (r_state == StOut);
    assign out_ch    = r_out_ch;
    assign out_pos   = r_out_pos;
    assign out_vel   = r_out_vel;
    assign err_ch    = r_err;

endmodule

// File: tb/tb_kf_track_mc.sv
// Self-checking bench for kf_track_mc: vector table through a scoreboard plus corner sequences.
// Three channels on a 2-bit id so that in_ch = 3 is an out-of-range id.
module tb_kf_track_mc;

    localparam int unsigned W    = 24;
    localparam int unsigned FRAC = 14;
    localparam int unsigned NCH  = 3;
    localparam int unsigned CHW  = 2;

    localparam logic [W-1:0] Q_HALF = 24'h002000;
    localparam logic [W-1:0] Q_QTR  = 24'h001000;
    localparam logic [W-1:0] Q_ONE  = 24'h004000;
    localparam logic [W-1:0] Q_MAX  = 24'h7FFFFF;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr = 1'b0;
    logic [W-1:0]   cfg_k1 = '0, cfg_k2 = '0, cfg_dt = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [CHW-1:0] in_ch = '0;
    logic [W-1:0]   in_meas = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [CHW-1:0] out_ch;
    logic [W-1:0]   out_pos, out_vel;
    logic           err_ch;

    always #5 clk = ~clk;

    kf_track_mc #(
        .W    (W),
        .FRAC (FRAC),
        .NCH  (NCH),
        .CHW  (CHW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .cfg_k1    (cfg_k1),
        .cfg_k2    (cfg_k2),
        .cfg_dt    (cfg_dt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_meas   (in_meas),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_pos   (out_pos),
        .out_vel   (out_vel),
        .err_ch    (err_ch)
    );

    typedef struct {
        logic [CHW-1:0] ch;
        logic [W-1:0]   z, k1, k2, dt;
        logic           clr_first;
        logic [W-1:0]   pos, vel;
    } vec_t;

    typedef struct {
        logic [CHW-1:0] ch;
        logic [W-1:0]   pos, vel;
        int             acc;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    vec_t         vecs[14];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    bit           seen = 1'b0;
    logic [W-1:0] hp, hv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: latency on first sight of a result, contents on handshake.
    always @(negedge clk) begin
        if (out_valid && !seen) begin
            seen = 1'b1;
            chk("sb_has_entry", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) chk("latency", 64'(cyc - sbq[0].acc), 64'd3);
        end
        if (out_valid && out_ready) begin
            seen = 1'b0;
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("out_ch", 64'(out_ch), 64'(mon_e.ch));
                chk("out_pos", 64'(out_pos), 64'(mon_e.pos));
                chk("out_vel", 64'(out_vel), 64'(mon_e.vel));
            end
        end
    end

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 64'(t < 200), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_ch    = v.ch;
        in_meas  = v.z;
        cfg_k1   = v.k1;
        cfg_k2   = v.k2;
        cfg_dt   = v.dt;
    endtask

    task automatic send(input vec_t v);
        int t = 0;
        if (v.clr_first) begin
            drain();
            pulse_clr();
        end
        @(negedge clk);
        drive(v);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", 64'(t < 100), 64'd1);
        sbq.push_back('{ch: v.ch, pos: v.pos, vel: v.vel, acc: cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{ch: 0, z: 24'h004000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                     pos: 24'h004000, vel: 24'h000000};
        vecs[1]  = '{ch: 0, z: 24'h008000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                     pos: 24'h006000, vel: 24'h001000};
        vecs[2]  = '{ch: 0, z: 24'h008000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                     pos: 24'h007400, vel: 24'h001600};
        vecs[3]  = '{ch: 0, z: 24'h004000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 1,
                     pos: 24'h004000, vel: 24'h000000};
        vecs[4]  = '{ch: 2, z: 24'h80C000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                     pos: 24'h80C000, vel: 24'h000000};
        vecs[5]  = '{ch: 0, z: 24'h008000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                     pos: 24'h006000, vel: 24'h001000};
        vecs[6]  = '{ch: 2, z: 24'h80C000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                     pos: 24'h80C000, vel: 24'h000000};
        vecs[7]  = '{ch: 0, z: 24'h008000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                     pos: 24'h007400, vel: 24'h001600};
        vecs[8]  = '{ch: 1, z: 24'h000000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                     pos: 24'h000000, vel: 24'h000000};
        vecs[9]  = '{ch: 1, z: 24'h804000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                     pos: 24'h802000, vel: 24'h801000};
        vecs[10] = '{ch: 1, z: 24'h000000, k1: Q_ONE, k2: Q_MAX, dt: Q_ONE, clr_first: 1,
                     pos: 24'h000000, vel: 24'h000000};
        vecs[11] = '{ch: 1, z: Q_MAX, k1: Q_ONE, k2: Q_MAX, dt: Q_ONE, clr_first: 0,
                     pos: Q_MAX, vel: Q_MAX};
        vecs[12] = '{ch: 1, z: Q_MAX, k1: Q_ONE, k2: Q_MAX, dt: Q_ONE, clr_first: 0,
                     pos: Q_MAX, vel: Q_MAX};
        vecs[13] = '{ch: 2, z: 24'h800000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                     pos: 24'h000000, vel: 24'h000000};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pos", 64'(out_pos), 64'd0);
        chk("rst_err_ch", 64'(err_ch), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i]) send(vecs[i]);
        drain();

        // Backpressure: result held stable, next sample waits for release.
        @(posedge clk);
        #1 out_ready = 1'b0;
        send('{ch: 0, z: 24'h004000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
               pos: 24'h004000, vel: 24'h000000});
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        hp = out_pos;
        hv = out_vel;
        drive('{ch: 0, z: 24'h008000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                pos: 24'h0, vel: 24'h0});
        repeat (20) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_pos", 64'(out_pos), 64'(hp));
            chk("hold_vel", 64'(out_vel), 64'(hv));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        chk("hold_pos_value", 64'(hp), 64'h004000);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send('{ch: 0, z: 24'h008000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
               pos: 24'h006000, vel: 24'h001000});
        drain();

        // Out-of-range channel is dropped and flagged; the next sample runs normally.
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = 2'd3;
        in_meas  = 24'h004000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("err_no_out", 64'(out_valid), 64'd0);
        end
        chk("err_ch_set", 64'(err_ch), 64'd1);
        send('{ch: 0, z: 24'h008000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
               pos: 24'h007400, vel: 24'h001600});
        drain();
        pulse_clr();
        chk("err_ch_sticky", 64'(err_ch), 64'd1);

        // Reset two edges after accept aborts the sample.
        @(negedge clk);
        drive('{ch: 0, z: 24'h004000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                pos: 24'h0, vel: 24'h0});
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("rst_abort_valid", 64'(out_valid), 64'd0);
        end
        chk("rst_abort_pos", 64'(out_pos), 64'd0);
        chk("rst_abort_vel", 64'(out_vel), 64'd0);
        chk("rst_abort_ch", 64'(out_ch), 64'd0);
        chk("rst_abort_err", 64'(err_ch), 64'd0);
        chk("rst_abort_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        send('{ch: 0, z: 24'h008000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
               pos: 24'h008000, vel: 24'h000000});
        drain();

        // clr during UPD: result still delivered, writeback dropped.
        @(negedge clk);
        drive('{ch: 0, z: 24'h004000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
                pos: 24'h0, vel: 24'h0});
        chk("clr_upd_ready", 64'(in_ready), 64'd1);
        sbq.push_back('{ch: 0, pos: 24'h006000, vel: 24'h801000, acc: cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        send('{ch: 0, z: 24'h00C000, k1: Q_HALF, k2: Q_QTR, dt: Q_HALF, clr_first: 0,
               pos: 24'h00C000, vel: 24'h000000});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kf_track_mc.md
Name: kf_track_mc

Overview:
- Multi-channel, time-multiplexed, steady-state 2-state (position/velocity) Kalman tracker.
- Next generation of the single-channel angle filter: parametrised width, fraction bits and channel count.
- Gains and dt are runtime-programmable; input and output use valid/ready handshakes.
- Per-channel first-sample initialisation and a saturating datapath.
- Sits between the angle-measurement front end and the downstream consumers; all I/O is sign-magnitude fixed point.

Parameters:
- W, 24, data width of all sign-magnitude values (sign bit plus W-1 magnitude bits).
- FRAC, 14, fractional bits of every value, including gains and dt.
- NCH, 4, number of channels, at least 1.
- CHW, 2, channel-id width; must satisfy 2**CHW >= NCH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous pulse; clears every channel's init flag, position and velocity.
- cfg_k1  in  W  position gain K1, sign-magnitude Q(FRAC); sampled at input accept.
- cfg_k2  in  W  velocity gain K2, sign-magnitude Q(FRAC); sampled at input accept.
- cfg_dt  in  W  sample interval dt, sign-magnitude Q(FRAC); sampled at input accept.
- in_valid  in  1  a measurement is offered.
- in_ready  out  1  block can accept a measurement.
- in_ch  in  CHW  channel of the offered measurement.
- in_meas  in  W  measurement z.
- out_valid  out  1  a result is presented.
- out_ready  in  1  downstream accepts the result.
- out_ch  out  CHW  channel of the result.
- out_pos  out  W  filtered position.
- out_vel  out  W  filtered velocity.
- err_ch  out  1  sticky flag: a sample was offered with in_ch >= NCH.

Behaviour:
- Reset values: in_ready=0 while rst_n=0, then 1 in IDLE. out_valid=0, out_ch=0, out_pos=0, out_vel=0, err_ch=0. All state arrays and init flags are 0. FSM is in IDLE.
- Reset mid-operation aborts the sample in flight. No output is produced for it.
- FSM: IDLE -> PRED -> CORR -> UPD -> OUT -> IDLE.
- IDLE
  - in_ready=1.
  - Accept on in_valid && in_ready. Latch ch, z, K1, K2 and dt; go to PRED.
  - If in_ch >= NCH: set err_ch, drop the sample, stay in IDLE.
- PRED: pp = p[ch] + sat(dt*v[ch]).
- CORR: r = sat(z - pp); m1 = sat(K1*r).
- UPD
  - Compute p' = sat(pp + m1) and v' = sat(v[ch] + sat(K2*r)).
  - Write p' and v' back to the channel state and load the output registers.
  - If init[ch] = 0: p' = z, v' = 0, set init[ch].
- OUT
  - out_valid=1, in_ready=0.
  - On out_ready, go to IDLE (out_valid=0 in the next cycle).
  - Outputs stay stable while out_ready=0.
- Latency: the accept edge is A. out_valid is high in the cycle after edge A+3. Throughput is at most one sample per 5 cycles with out_ready tied high.
- A single shared multiplier is permitted, one product per state.
- Arithmetic
  - Convert inputs to two's complement internally, width W.
  - Products are 2W wide. Round by adding 2**(FRAC-1), then arithmetic shift right by FRAC.
  - Every sum and product result saturates to the symmetric range ±(2**(W-1)-1).
  - Negative zero (sign=1, mag=0) on any input is treated as 0.
  - Outputs are never negative zero.
- clr
  - Clears the state arrays and init flags in the same edge.
  - If asserted while a sample is in flight, that sample finishes and its result is output, but its writeback is suppressed.
  - clr does not clear err_ch (only reset clears it).
- Channels are fully independent. A write to channel a never alters channel b.

Decomposition:
- Shared package kf_pkg holds:
  - the constants SM_MAX = 2**(W-1)-1 and the state encoding;
  - the functions sm_to_tc, tc_to_sm (no negative zero), sat_w and mul_q (round, shift, saturate).
- One sub-module, kf_qmul: registered-free signed W x W multiply with round/shift/saturate, instantiated once and shared by the FSM.

Test Plan:
- FRAC=14, K1=0.5, K2=0.25, dt=0.5. Ch0 z=1.0 -> pos=1.0, vel=0.0 (init). Then z=2.0 -> pos=1.5, vel=0.25. Then z=2.0 -> pos=1.8125, vel=0.34375. out_ch=0 each time; out_valid in the cycle after A+3.
- Interleave ch0 and ch2 with the ch0 sequence above plus ch2 z=-3.0, -3.0. The ch0 results are identical to the first test; ch2 gives pos=-3.0, vel=0 then pos=-3.0, vel=0.
- Hold out_ready=0 for 20 cycles. out_valid stays 1 with stable data, in_ready stays 0, and an offered sample is not accepted until after the release.
- K1=1.0, dt=1.0, p=v=SM_MAX (values 511.99994). Then z=0x7FFFFF -> pos=0x7FFFFF, no wrap. Also z=negative zero (0x800000) on a fresh channel -> pos=0x000000.
- in_ch=NCH -> err_ch=1, no out_valid. Next valid sample is processed normally.
- rst_n low at edge A+2 -> out_valid never asserts and all outputs are 0. clr during UPD -> result output, then the next sample on that channel re-initialises (vel=0).
